mul_arb: RTL

MUL_ARB -- requirements
Module: mul_arb

---
 rtl/mul_arb.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mul_arb.sv
// Round-robin arbiter that shares one multiplier between four requesters.
// A granted request drives mul_a/mul_b and pulses mul_start, waits for
// mul_finish (or a TIMEOUT-cycle budget), then returns a one-cycle done pulse
// to the served requester together with the product and an error flag.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   req[3:0]        per-requester request level
//   a_in, b_in      packed operands, requester i in [i*WIDTH +: WIDTH]
//   done[3:0]       one-hot completion pulse to the served requester
//   res_out, err    product (0 on timeout) and timeout flag, held until next done
//   busy, owner     not-idle flag and index of the current grant
//   mul_start       one-cycle start pulse to the shared multiplier
//   mul_a, mul_b    operands latched at grant
//   mul_res         multiplier product
//   mul_finish      multiplier completion flag, only honoured while waiting
module mul_arb #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   a_in,
  input  logic [4*WIDTH-1:0]   b_in,
  output logic [3:0]           done,
  output logic [2*WIDTH-1:0]   res_out,
  output logic                 err,
  output logic                 busy,
  output logic [1:0]           owner,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_res,
  input  logic                 mul_finish
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned CW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state, state_d;
  logic [1:0]           ptr, ptr_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [1:0]           owner_d;
  logic [WIDTH-1:0]     a_d, b_d;
  logic                 start_d;
  logic [3:0]           done_d;
  logic [2*WIDTH-1:0]   res_d;
  logic                 err_d;
  logic                 busy_d;
  logic                 grant_found;
  logic [1:0]           grant_idx;

  // Round-robin search: walk from ptr upward; the loop runs high-to-low so
  // the closest requester to ptr is the last (winning) assignment.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        grant_found = 1'b1;
        grant_idx   = ptr + 2'(k);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    owner_d = owner;
    a_d     = mul_a;
    b_d     = mul_b;
    start_d = 1'b0;
    done_d  = 4'b0000;
    res_d   = res_out;
    err_d   = err;

    case (state)
      S_IDLE: begin
        if (grant_found) begin
          state_d = S_START;
          owner_d = grant_idx;
          a_d     = a_in[32'(grant_idx) * WIDTH +: WIDTH];
          b_d     = b_in[32'(grant_idx) * WIDTH +: WIDTH];
          start_d = 1'b1;
          cnt_d   = '0;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt + CW'(1);
        // A finish on the same cycle the budget runs out still counts.
        if (mul_finish) begin
          state_d = S_DONE;
          res_d   = mul_res;
          err_d   = 1'b0;
          done_d  = 4'(1) << owner;
        end else if (cnt_d == CW'(TIMEOUT)) begin
          state_d = S_DONE;
          res_d   = '0;
          err_d   = 1'b1;
          done_d  = 4'(1) << owner;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = owner + 2'd1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= 2'd0;
      cnt       <= '0;
      owner     <= 2'd0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_start <= 1'b0;
      done      <= 4'b0000;
      res_out   <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      owner     <= owner_d;
      mul_a     <= a_d;
      mul_b     <= b_d;
      mul_start <= start_d;
      done      <= done_d;
      res_out   <= res_d;
      err       <= err_d;
      busy      <= busy_d;
    end
  end

endmodule
